// File: rtl/galois_lfsr_pkg.sv
// Shared definitions for the PRBS-8 checker: polynomial, history tap mask,
// checker state encoding and the history predict/shift helpers.
package galois_lfsr_pkg;

    // Generator polynomial x^8+x^4+x^3+x^2+1.
    localparam logic [8:0] POLY     = 9'h11D;
    // Taps on hist (hist[0] = s[n-1]): s[n-4], s[n-5], s[n-6], s[n-8].
    localparam logic [7:0] TAP_MASK = 8'hB8;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

    // Next sequence bit implied by the last eight bits.
    function automatic logic prbs8_predict(input logic [7:0] hist);
        return ^(hist & TAP_MASK);
    endfunction

    // Push a new sequence bit into the history; the oldest bit drops out.
    function automatic logic [7:0] prbs8_shift(input logic [7:0] hist, input logic b);
        return (hist << 1) | {7'b0000000, b};
    endfunction

    // Bit reversal, used to tie TAP_MASK back to POLY at elaboration.
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/galois_lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 32,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum_s;

    // Next count: clear, else clamp the one-bit-wider sum at all-ones.
    always_comb begin
        sum_s = {1'b0, count_q} + (WIDTH + 1)'(inc);
        if (clear) begin
            count_d = '0;
        end else if (sum_s[WIDTH]) begin
            count_d = '1;
        end else begin
            count_d = sum_s[WIDTH-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/galois_lfsr_checker.sv
// PRBS-8 receive checker: self-synchronises on the received stream, then
// flywheels the expected sequence and counts checked bits and bit errors.
module galois_lfsr_checker
    import galois_lfsr_pkg::*;
#(
    parameter int BITS_PER_CLOCK = 1,
    parameter int LOCK_THRESH    = 16,
    parameter int UNLOCK_WORDS   = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITS_PER_CLOCK-1:0] data_in,
    input  logic                      data_valid,
    input  logic                      clear,
    output logic                      locked,
    output logic [2:0]                bit_err,
    output logic [CNT_WIDTH-1:0]      bit_count,
    output logic [CNT_WIDTH-1:0]      err_count
);

    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int BW = $clog2(UNLOCK_WORDS + 1);

    if (BITS_PER_CLOCK < 1 || BITS_PER_CLOCK > 4) begin : g_bad_width
        $error("galois_lfsr_checker: BITS_PER_CLOCK must be 1..4");
    end
    if (LOCK_THRESH < 1 || UNLOCK_WORDS < 1) begin : g_bad_thresh
        $error("galois_lfsr_checker: LOCK_THRESH and UNLOCK_WORDS must be >= 1");
    end
    if (TAP_MASK != bit_rev8(POLY[7:0])) begin : g_bad_taps
        $error("galois_lfsr_checker: TAP_MASK does not match POLY");
    end

    chk_state_e     state_q, state_d;
    logic [7:0]     hist_q, hist_d;
    logic [3:0]     fill_q, fill_d;
    logic [GW-1:0]  good_q, good_d;
    logic [BW-1:0]  bad_q, bad_d;
    logic [2:0]     bit_err_q, bit_err_d;

    // Word-unroll working values.
    logic [7:0]     hist_w_s;
    logic [3:0]     fill_w_s;
    logic [GW-1:0]  good_w_s;
    logic [2:0]     err_w_s;
    logic           pred_s;
    logic [2:0]     bits_inc_s;
    logic [2:0]     errs_inc_s;

    // Process one word bit-serially, oldest bit first, in the state held at word start.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        good_d     = good_q;
        bad_d      = bad_q;
        bit_err_d  = 3'd0;
        bits_inc_s = 3'd0;
        errs_inc_s = 3'd0;
        hist_w_s   = hist_q;
        fill_w_s   = fill_q;
        good_w_s   = good_q;
        err_w_s    = 3'd0;
        pred_s     = 1'b0;
        if (data_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    for (int i = BITS_PER_CLOCK - 1; i >= 0; i--) begin
                        pred_s = prbs8_predict(hist_w_s);
                        if (fill_w_s < 4'd8) begin
                            fill_w_s = fill_w_s + 4'd1;
                        end else if (data_in[i] == pred_s) begin
                            if (good_w_s < GW'(LOCK_THRESH)) begin
                                good_w_s = good_w_s + GW'(1);
                            end else begin
                                good_w_s = good_w_s;
                            end
                        end else begin
                            good_w_s = '0;
                        end
                        // Searching trains on what was actually received.
                        hist_w_s = prbs8_shift(hist_w_s, data_in[i]);
                    end
                    // An all-zero window satisfies the recurrence trivially; never lock on it.
                    if (hist_w_s == 8'h00) begin
                        good_w_s = '0;
                    end else begin
                        good_w_s = good_w_s;
                    end
                    hist_d = hist_w_s;
                    fill_d = fill_w_s;
                    if (good_w_s == GW'(LOCK_THRESH)) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d  = good_w_s;
                    end
                end
                ST_LOCKED: begin
                    for (int i = BITS_PER_CLOCK - 1; i >= 0; i--) begin
                        pred_s   = prbs8_predict(hist_w_s);
                        err_w_s  = err_w_s + {2'b00, data_in[i] ^ pred_s};
                        // Flywheel: a flipped bit never pollutes the history.
                        hist_w_s = prbs8_shift(hist_w_s, pred_s);
                    end
                    hist_d     = hist_w_s;
                    bit_err_d  = err_w_s;
                    bits_inc_s = 3'(BITS_PER_CLOCK);
                    errs_inc_s = err_w_s;
                    if (err_w_s != 3'd0) begin
                        if (bad_q == BW'(UNLOCK_WORDS - 1)) begin
                            state_d = ST_SEARCH;
                            good_d  = '0;
                            fill_d  = 4'd0;
                            bad_d   = '0;
                        end else begin
                            bad_d   = bad_q + BW'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                    fill_d  = 4'd0;
                    bad_d   = '0;
                end
            endcase
        end else begin
            bit_err_d = 3'd0;
        end
    end

    // Checker state, history and per-word error report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            hist_q    <= 8'h00;
            fill_q    <= 4'd0;
            good_q    <= '0;
            bad_q     <= '0;
            bit_err_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            bit_err_q <= bit_err_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(3)) u_bit_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (clear),
        .inc   (bits_inc_s),
        .count (bit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(3)) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (clear),
        .inc   (errs_inc_s),
        .count (err_count)
    );

    assign locked  = (state_q == ST_LOCKED);
    assign bit_err = bit_err_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Bench for galois_lfsr_checker: a 1-bit/4-bit-counter instance driven from a
// phase table with hand-derived end values, and a 4-bit/32-bit-counter instance
// driven directed then randomly; both checked every cycle against a model.
module tb_galois_lfsr_checker;

    localparam int LT = 16;
    localparam int UW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [0:0]  d1_data;
    logic        d1_valid, d1_clear, d1_locked;
    logic [2:0]  d1_bit_err;
    logic [3:0]  d1_bits, d1_errs;
    logic [3:0]  d4_data;
    logic        d4_valid, d4_clear, d4_locked;
    logic [2:0]  d4_bit_err;
    logic [31:0] d4_bits, d4_errs;

    galois_lfsr_checker #(.BITS_PER_CLOCK(1), .LOCK_THRESH(LT), .UNLOCK_WORDS(UW), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .data_in(d1_data), .data_valid(d1_valid), .clear(d1_clear),
        .locked(d1_locked), .bit_err(d1_bit_err), .bit_count(d1_bits), .err_count(d1_errs));

    galois_lfsr_checker #(.BITS_PER_CLOCK(4), .LOCK_THRESH(LT), .UNLOCK_WORDS(UW), .CNT_WIDTH(32)) dut4 (
        .clk(clk), .reset(reset), .data_in(d4_data), .data_valid(d4_valid), .clear(d4_clear),
        .locked(d4_locked), .bit_err(d4_bit_err), .bit_count(d4_bits), .err_count(d4_errs));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model, index 0 = dut1, 1 = dut4. Sequences kept as bit queues,
    // element 0 oldest: s[n-8] .. element 7 newest: s[n-1].
    int      m_b[2]   = '{1, 4};
    longint  m_max[2] = '{15, 64'h0000_0000_FFFF_FFFF};
    bit      m_lock[2];
    int      m_fill[2], m_good[2], m_bad[2], m_bit_err[2];
    longint  m_bits[2], m_errs[2];
    bit      m_hist[2][$];
    bit      tx[2][$];
    int      inv_left[2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // s[n] = s[n-4]^s[n-5]^s[n-6]^s[n-8] over a stored window.
    function automatic bit m_pred(input int k);
        return m_hist[k][4] ^ m_hist[k][3] ^ m_hist[k][2] ^ m_hist[k][0];
    endfunction

    function automatic void m_push(input int k, input bit b);
        m_hist[k].push_back(b);
        void'(m_hist[k].pop_front());
    endfunction

    // Transmit-side sequence source following the same recurrence.
    function automatic bit tx_next(input int k);
        bit b;
        b = tx[k][4] ^ tx[k][3] ^ tx[k][2] ^ tx[k][0];
        tx[k].push_back(b);
        void'(tx[k].pop_front());
        return b;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 1'b0; m_fill[k] = 0; m_good[k] = 0; m_bad[k] = 0;
            m_bit_err[k] = 0; m_bits[k] = 0; m_errs[k] = 0;
            m_hist[k] = {};
            for (int j = 0; j < 8; j++) m_hist[k].push_back(1'b0);
        end
    endtask

    task automatic model_word(input int k, input bit v, input logic [3:0] w, input bit clr);
        if (v) begin
            if (!m_lock[k]) begin
                bit any;
                for (int i = m_b[k] - 1; i >= 0; i--) begin
                    if (m_fill[k] < 8) m_fill[k]++;
                    else if (w[i] == m_pred(k)) m_good[k]++;
                    else m_good[k] = 0;
                    m_push(k, w[i]);
                end
                any = 1'b0;
                for (int j = 0; j < 8; j++) any |= m_hist[k][j];
                if (!any) m_good[k] = 0;
                if (m_good[k] >= LT) begin
                    m_lock[k] = 1'b1;
                    m_bad[k]  = 0;
                end
                m_bit_err[k] = 0;
            end else begin
                int e;
                bit p;
                e = 0;
                for (int i = m_b[k] - 1; i >= 0; i--) begin
                    p = m_pred(k);
                    if (w[i] != p) e++;
                    m_push(k, p);
                end
                m_bit_err[k] = e;
                m_bits[k] = sat_add(m_bits[k], m_b[k], m_max[k]);
                m_errs[k] = sat_add(m_errs[k], e, m_max[k]);
                m_bad[k]  = (e != 0) ? m_bad[k] + 1 : 0;
                if (m_bad[k] == UW) begin
                    m_lock[k] = 1'b0; m_good[k] = 0; m_fill[k] = 0; m_bad[k] = 0;
                end
            end
        end else begin
            m_bit_err[k] = 0;
        end
        if (clr) begin
            m_bits[k] = 0;
            m_errs[k] = 0;
        end
    endtask

    task automatic check_all();
        chk("d1_locked",  d1_locked,  m_lock[0]);
        chk("d1_bit_err", d1_bit_err, m_bit_err[0]);
        chk("d1_bits",    d1_bits,    m_bits[0]);
        chk("d1_errs",    d1_errs,    m_errs[0]);
        chk("d4_locked",  d4_locked,  m_lock[1]);
        chk("d4_bit_err", d4_bit_err, m_bit_err[1]);
        chk("d4_bits",    d4_bits,    m_bits[1]);
        chk("d4_errs",    d4_errs,    m_errs[1]);
    endtask

    // Drive both instances for one clock, update the model, sample 1 time unit later.
    task automatic apply(input bit v1, input logic [3:0] w1, input bit c1,
                         input bit v4, input logic [3:0] w4, input bit c4);
        d1_valid = v1; d1_data = w1[0:0]; d1_clear = c1;
        d4_valid = v4; d4_data = w4;      d4_clear = c4;
        @(posedge clk);
        model_word(0, v1, w1, c1);
        model_word(1, v4, w4, c4);
        #1;
        check_all();
    endtask

    // Outputs must clear as soon as reset rises, before any clock edge.
    task automatic do_reset();
        d1_valid = 1'b0; d1_clear = 1'b0; d4_valid = 1'b0; d4_clear = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [3:0] prbs_word(input int k);
        logic [3:0] w;
        w = 4'h0;
        for (int i = m_b[k] - 1; i >= 0; i--) w[i] = tx_next(k);
        return w;
    endfunction

    // Random word: mostly clean, sometimes flipped bits or an inverted burst.
    function automatic logic [3:0] rand_word(input int k);
        logic [3:0] w;
        logic [3:0] msk;
        int r;
        w   = prbs_word(k);
        msk = (m_b[k] == 4) ? 4'hF : 4'h1;
        r   = $urandom_range(0, 199);
        if (inv_left[k] > 0) begin
            inv_left[k]--;
            w = ~w & msk;
        end else if (r == 0) begin
            inv_left[k] = $urandom_range(2, 6);
        end else if (r < 20) begin
            w = w ^ (4'(1 << $urandom_range(0, m_b[k] - 1)) & msk);
        end else if (r < 28) begin
            w = w ^ (4'($urandom_range(0, 15)) & msk);
        end else begin
            w = w;
        end
        return w;
    endfunction

    typedef struct {
        bit rst;
        int ncyc;
        int mode;    // 0 prbs, 1 zeros, 2 inverted, 3 flip every other word, 4 flip every word
        bit gap;     // valid on 1 of every 3 cycles
        bit clr;
        bit e_lock;
        int e_bits;
        int e_errs;
    } phase_t;

    phase_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        bit v;
        int widx;

        tbl[0]  = '{1'b1, 23,  0, 1'b0, 1'b0, 1'b0, 0,  0};
        tbl[1]  = '{1'b0, 1,   0, 1'b0, 1'b0, 1'b1, 0,  0};
        tbl[2]  = '{1'b0, 10,  0, 1'b0, 1'b0, 1'b1, 10, 0};
        tbl[3]  = '{1'b0, 10,  0, 1'b0, 1'b0, 1'b1, 15, 0};
        tbl[4]  = '{1'b0, 40,  3, 1'b0, 1'b0, 1'b1, 15, 15};
        tbl[5]  = '{1'b0, 1,   4, 1'b0, 1'b1, 1'b1, 0,  0};
        tbl[6]  = '{1'b0, 1,   0, 1'b0, 1'b0, 1'b1, 1,  0};
        tbl[7]  = '{1'b0, 4,   2, 1'b0, 1'b0, 1'b0, 5,  4};
        tbl[8]  = '{1'b0, 23,  0, 1'b0, 1'b0, 1'b0, 5,  4};
        tbl[9]  = '{1'b0, 1,   0, 1'b0, 1'b0, 1'b1, 5,  4};
        tbl[10] = '{1'b1, 200, 1, 1'b0, 1'b0, 1'b0, 0,  0};
        tbl[11] = '{1'b1, 72,  0, 1'b1, 1'b0, 1'b1, 0,  0};
        tbl[12] = '{1'b0, 30,  0, 1'b1, 1'b0, 1'b1, 10, 0};

        for (int k = 0; k < 2; k++) begin
            tx[k] = {};
            tx[k].push_back(1'b1);
            for (int j = 1; j < 8; j++) tx[k].push_back(1'b0);
            inv_left[k] = 0;
        end
        reset = 1'b0;
        d1_valid = 1'b0; d1_data = 1'b0; d1_clear = 1'b0;
        d4_valid = 1'b0; d4_data = 4'h0; d4_clear = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Table phases on the 1-bit instance.
        for (int p = 0; p < 13; p++) begin
            if (tbl[p].rst) do_reset();
            widx = 0;
            for (int c = 0; c < tbl[p].ncyc; c++) begin
                v = tbl[p].gap ? ((c % 3) == 0) : 1'b1;
                w = 4'h0;
                if (v) begin
                    w[0] = tx_next(0);
                    case (tbl[p].mode)
                        1: w[0] = 1'b0;
                        2: w[0] = ~w[0];
                        3: w[0] = w[0] ^ ((widx % 2) == 0);
                        4: w[0] = ~w[0];
                        default: w[0] = w[0];
                    endcase
                    widx++;
                end
                apply(v, w, tbl[p].clr, 1'b0, 4'h0, 1'b0);
            end
            chk($sformatf("ph%0d_locked", p), d1_locked, tbl[p].e_lock);
            chk($sformatf("ph%0d_bits", p),   d1_bits,   tbl[p].e_bits);
            chk($sformatf("ph%0d_errs", p),   d1_errs,   tbl[p].e_errs);
        end

        // Reset while locked: outputs drop immediately, relock after 24 bits.
        reset = 1'b1;
        #1;
        chk("midrst_locked", d1_locked, 0);
        chk("midrst_bits",   d1_bits,   0);
        reset = 1'b0;
        do_reset();
        for (int c = 0; c < 23; c++) apply(1'b1, {3'b000, tx_next(0)}, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("relock_23_locked", d1_locked, 0);
        apply(1'b1, {3'b000, tx_next(0)}, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("relock_24_locked", d1_locked, 1);

        // 4-bit instance: lock after 6 words, then single and triple bit flips.
        do_reset();
        for (int c = 0; c < 5; c++) apply(1'b0, 4'h0, 1'b0, 1'b1, prbs_word(1), 1'b0);
        chk("b4_lock5", d4_locked, 0);
        apply(1'b0, 4'h0, 1'b0, 1'b1, prbs_word(1), 1'b0);
        chk("b4_lock6", d4_locked, 1);
        apply(1'b0, 4'h0, 1'b0, 1'b1, prbs_word(1) ^ 4'b0100, 1'b0);
        chk("b4_flip1_biterr", d4_bit_err, 1);
        chk("b4_flip1_errs",   d4_errs,    1);
        apply(1'b0, 4'h0, 1'b0, 1'b1, prbs_word(1), 1'b0);
        chk("b4_clean_biterr", d4_bit_err, 0);
        chk("b4_clean_locked", d4_locked,  1);
        apply(1'b0, 4'h0, 1'b0, 1'b1, prbs_word(1) ^ 4'b1011, 1'b0);
        chk("b4_flip3_biterr", d4_bit_err, 3);
        chk("b4_flip3_errs",   d4_errs,    4);
        chk("b4_flip3_bits",   d4_bits,    12);

        // Random traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            bit v1, v4, c1, c4;
            logic [3:0] w1, w4;
            if ($urandom_range(0, 999) == 0) do_reset();
            v1 = ($urandom_range(0, 3) != 0);
            v4 = ($urandom_range(0, 3) != 0);
            c1 = ($urandom_range(0, 59) == 0);
            c4 = ($urandom_range(0, 59) == 0);
            w1 = v1 ? rand_word(0) : 4'h0;
            w4 = v4 ? rand_word(1) : 4'h0;
            apply(v1, w1, c1, v4, w4, c4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
